mux_gate_seq: RTL and testbench

- Bit-serial sequencer for the mux-based universal gate datapath (NAND/NOR built from 2:1 muxes).
- Accepts W-bit operand pairs and an opcode over a valid/ready handshake.
- Evaluates one bit per cycle, LSB first, through a single shared 2:1-mux gate cell and returns the W-bit result over a second valid/ready handshake.
- Lets the team exercise mux-built gates on word-wide data with minimal hardware.

---
 rtl/mux_gate_seq.sv | 191 +++++++++++++++++++
 tb/tb_mux_gate_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_gate_seq.sv
// mux_gate_seq: bit-serial sequencer around one mux-built universal gate cell.
// Operands are latched on request acceptance, evaluated LSB first at one bit
// per clock through a single 2:1 mux, and the assembled word is presented
// over a valid/ready output handshake.

// Plain 2:1 multiplexer; the only logic primitive the gate cell is built from.
module mux_gate_mux2 (
    input  logic i_sel,
    input  logic i_d0,
    input  logic i_d1,
    output logic o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// Universal gate cell: the A bit drives the mux select, and the opcode only
// chooses which of {0, 1, b, ~b} feeds each mux data leg.
module mux_gate_cell (
    input  logic       i_a_bit,
    input  logic       i_b_bit,
    input  logic [2:0] i_op,
    output logic       o_y
);
    localparam logic [2:0] OP_NAND  = 3'b000;
    localparam logic [2:0] OP_NOR   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_NOT_A = 3'b110;
    localparam logic [2:0] OP_BUF_A = 3'b111;

    logic w_d0;  // leg taken when the A bit is 0
    logic w_d1;  // leg taken when the A bit is 1

    // Select the two mux data legs for the requested function.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        w_d0 = 1'b0;
        w_d1 = 1'b0;
        case (i_op)
            OP_NAND:  begin w_d1 = ~i_b_bit; w_d0 = 1'b1;     end
            OP_NOR:   begin w_d1 = 1'b0;     w_d0 = ~i_b_bit; end
            OP_AND:   begin w_d1 = i_b_bit;  w_d0 = 1'b0;     end
            OP_OR:    begin w_d1 = 1'b1;     w_d0 = i_b_bit;  end
            OP_XOR:   begin w_d1 = ~i_b_bit; w_d0 = i_b_bit;  end
            OP_XNOR:  begin w_d1 = i_b_bit;  w_d0 = ~i_b_bit; end
            OP_NOT_A: begin w_d1 = 1'b0;     w_d0 = 1'b1;     end
            OP_BUF_A: begin w_d1 = 1'b1;     w_d0 = 1'b0;     end
            default:  begin w_d1 = 1'b0;     w_d0 = 1'b0;     end
        endcase
    end

    mux_gate_mux2 u_mux (
        .i_sel (i_a_bit),
        .i_d0  (w_d0),
        .i_d1  (w_d1),
        .o_y   (o_y)
    );
endmodule

// Top level: handshake FSM, operand latches, bit counter and result shifter.
module mux_gate_seq #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [2:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result,
    output logic          busy,
    output logic [CW-1:0] bit_idx
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_in_ready;
    logic [W-1:0]  r_a_l;
    logic [W-1:0]  r_b_l;
    logic [2:0]    r_op_l;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_bit_idx;
    logic          w_accept;
    logic          w_last_bit;
    logic          w_cell_bit;

    // A request is taken only while the registered ready is up and no abort.
    assign w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready && !clr;
    assign w_last_bit = (r_bit_idx == CW'(W - 1));

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign bit_idx   = r_bit_idx;

    // One shared gate cell evaluates the current bit of the latched operands.
    mux_gate_cell u_cell (
        .i_a_bit (r_a_l[r_bit_idx]),
        .i_b_bit (r_b_l[r_bit_idx]),
        .i_op    (r_op_l),
        .o_y     (w_cell_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; clr overrides every other event.
    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid && r_in_ready) w_next_state = S_RUN;
                S_RUN:  if (w_last_bit)             w_next_state = S_DONE;
                S_DONE: if (out_ready)              w_next_state = S_IDLE;
                default:                            w_next_state = S_IDLE;
            endcase
        end
    end

    // Registered ready: held low through reset and raised on the first edge
    // that registers IDLE, then tracks IDLE from there on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == S_IDLE);
        end
    end

    // Operand latches, bit counter and serial result build-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_l     <= '0;
            r_b_l     <= '0;
            r_op_l    <= '0;
            r_result  <= '0;
            r_bit_idx <= '0;
        end else if (clr) begin
            // Abort leaves the partial result in place; only the counter rewinds.
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_l     <= a;
                        r_b_l     <= b;
                        r_op_l    <= op;
                        r_result  <= '0;
                        r_bit_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_result[r_bit_idx] <= w_cell_bit;
                    // Counter wraps only when leaving RUN, so it never exceeds W-1.
                    if (w_last_bit) begin
                        r_bit_idx <= '0;
                    end else begin
                        r_bit_idx <= r_bit_idx + CW'(1);
                    end
                end
                default: begin
                    // DONE holds the result until the consumer takes it.
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_gate_seq.sv
// Directed testbench for mux_gate_seq (W=8). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_mux_gate_seq;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_NAND  = 3'b000;
    localparam logic [2:0] OP_NOR   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_NOT_A = 3'b110;
    localparam logic [2:0] OP_BUF_A = 3'b111;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          clr       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic [2:0]    op        = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [W-1:0]  result;
    logic [CW-1:0] bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_gate_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .bit_idx   (bit_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, check the result and the return to IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2:0] top, input logic [W-1:0] exp,
                          input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        a = ta; b = tb; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b in_ready=%b, required busy=1 in_ready=0", name, busy, in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 2 * W) begin tick(); n++; end
        n_checks++;
        if (n != W) begin
            n_fail++;
            $display("FAIL %s latency: %0d cycles, required %0d", name, n, W);
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, result, exp);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: out_valid=%b busy=%b in_ready=%b, required 0 0 1", name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== '0 || bit_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b ov=%b busy=%b res=%h idx=%0d, required all 0",
                     in_ready, out_valid, busy, result, bit_idx);
        end
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_all_ops();
        logic [2:0]   ops [8];
        logic [W-1:0] exps[8];
        string        nms [8];
        ops  = '{OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_AND, OP_OR, OP_NOT_A, OP_BUF_A};
        exps = '{8'hDB, 8'h42, 8'h99, 8'h66, 8'h24, 8'hBD, 8'h5A, 8'hA5};
        nms  = '{"nand", "nor", "xor", "xnor", "and", "or", "not_a", "buf_a"};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(8'hA5, 8'h3C, ops[i], exps[i], nms[i]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        a = 8'hA5; b = 8'h3C; op = OP_NAND; in_valid = 1'b1;
        tick();
        a = 8'h00; b = 8'hFF; op = OP_BUF_A;  // new request stays pending
        n = 0;
        while (out_valid !== 1'b1 && n < 2 * W) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || result !== 8'hDB || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: ov=%b res=%h rdy=%b, required 1 db 0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 8'hDB) begin
            n_fail++;
            $display("FAIL backpressure_release: ov=%b busy=%b res=%h, required 0 0 db",
                     out_valid, busy, result);
        end
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        a = 8'h5A; b = 8'hC3; op = OP_AND; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (bit_idx !== CW'(3)) begin
            n_fail++;
            $display("FAIL clr_setup_idx: got %0d, required 3", bit_idx);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_idx !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_mid_run: ov=%b busy=%b idx=%0d rdy=%b, required 0 0 0 1",
                     out_valid, busy, bit_idx, in_ready);
        end
        // clr together with in_valid in IDLE must not accept.
        in_valid = 1'b1; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vs_valid: busy=%b, required 0", busy);
        end
        run_op(8'hFF, 8'h00, OP_XOR, 8'hFF, "after_clr");
        // clr together with out_ready in DONE.
        out_ready = 1'b0;
        a = 8'h0F; b = 8'h0F; op = OP_AND; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        clr = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_in_done: ov=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        a = 8'h33; b = 8'h55; op = OP_OR; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            result !== '0 || bit_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: rdy=%b ov=%b busy=%b res=%h idx=%0d, required all 0",
                     in_ready, out_valid, busy, result, bit_idx);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(8'h0F, 8'hF0, OP_OR, 8'hFF, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta  [4];
        logic [W-1:0] tb  [4];
        logic [2:0]   to  [4];
        logic [W-1:0] exps[3];
        int acc_cyc[3];
        int n_acc, n_res, cyc;
        logic acc;
        ta   = '{8'hA5, 8'hFF, 8'h0F, 8'h00};
        tb   = '{8'h3C, 8'h0F, 8'hF0, 8'h00};
        to   = '{OP_AND, OP_AND, OP_OR, OP_XOR};
        exps = '{8'h24, 8'h0F, 8'hFF};
        n_acc = 0; n_res = 0; cyc = 0;
        out_ready = 1'b1;
        a = ta[0]; b = tb[0]; op = to[0]; in_valid = 1'b1;
        while ((n_acc < 3 || n_res < 3) && cyc < 60) begin
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                // Next operands appear while this operation is still running.
                a = ta[n_acc]; b = tb[n_acc]; op = to[n_acc];
                if (n_acc == 3) in_valid = 1'b0;
            end
            if (out_valid === 1'b1 && n_res < 3) begin
                n_checks++;
                if (result !== exps[n_res]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got %h, required %h", n_res, result, exps[n_res]);
                end
                n_res++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 3 || n_res != 3) begin
            n_fail++;
            $display("FAIL b2b_count: acc=%0d res=%0d, required 3 3", n_acc, n_res);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles, required %0d",
                             i, acc_cyc[i] - acc_cyc[i-1], W + 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_backpressure();
        test_clr();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
